// File: rtl/dmem_store_buffer.sv
// Store buffer and load front end for the 256x32 dual-port data SRAM.
// Latency: stores drain from the FIFO head one per cycle; a load responds in the cycle after it issues.
// Backpressure: st_ready drops while the FIFO is full; loads are always accepted.
module dmem_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_WIDTH+1:0]   st_addr,
    input  logic [1:0]              st_size,
    input  logic [31:0]             st_data,
    input  logic                    ld_valid,
    input  logic [ADDR_WIDTH+1:0]   ld_addr,
    input  logic [1:0]              ld_size,
    input  logic                    ld_unsigned,
    input  logic [TAG_W-1:0]        ld_tag,
    output logic                    resp_valid,
    output logic [TAG_W-1:0]        resp_tag,
    output logic [31:0]             resp_data,
    output logic                    err,
    output logic                    sb_empty,
    output logic                    csb0,
    output logic [3:0]              wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [31:0]             din0,
    output logic                    csb1,
    output logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [31:0]             dout1
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            mask;
        logic [31:0]           data;
    } sb_entry_t;

    sb_entry_t             fifo [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count, count_nxt;
    sb_entry_t             head, st_entry;
    logic                  st_bad, ld_bad, st_fire, ld_fire, drain;
    logic [ADDR_WIDTH-1:0] ld_word;
    logic [3:0]            fwd_mask;
    logic [31:0]           fwd_data;
    logic [PW-1:0]         fwd_idx;
    logic [3:0]            r_fmask;
    logic [31:0]           r_fdata, merged, shifted;
    logic [1:0]            r_off, r_size;
    logic                  r_uns;

    function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
    endfunction

    // Request qualification, drain arbitration and SRAM port drive
    always_comb begin
        st_bad   = misaligned(st_addr[1:0], st_size);
        ld_bad   = misaligned(ld_addr[1:0], ld_size);
        st_ready = (count < CNT_FULL);
        st_fire  = st_valid && st_ready && !st_bad;
        ld_fire  = ld_valid && !ld_bad;
        ld_word  = ld_addr[ADDR_WIDTH+1:2];
        head     = fifo[rd_ptr];
        // A same-word load wins the cycle so read and write never hit one address together
        drain    = (count != '0) && !(ld_fire && ld_word == head.addr);
        csb0     = !drain;
        wmask0   = drain ? head.mask : 4'b0000;
        addr0    = drain ? head.addr : '0;
        din0     = drain ? head.data : 32'h0;
        csb1     = !ld_fire;
        addr1    = ld_fire ? ld_word : '0;
        unique case ({st_fire, drain})
            2'b10:   count_nxt = count + (PW+1)'(1);
            2'b01:   count_nxt = count - (PW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Lane-align the incoming store into word address, byte mask and shifted data
    always_comb begin
        st_entry.addr = st_addr[ADDR_WIDTH+1:2];
        st_entry.data = st_data << {st_addr[1:0], 3'b000};
        case (st_size)
            2'b00:   st_entry.mask = 4'b0001 << st_addr[1:0];
            2'b01:   st_entry.mask = 4'b0011 << st_addr[1:0];
            default: st_entry.mask = 4'b1111;
        endcase
    end

    // Forwarding: walk pending entries oldest to youngest so later stores overwrite lanes
    always_comb begin
        fwd_mask = 4'b0000;
        fwd_data = 32'h0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count && fifo[fwd_idx].addr == ld_word) begin
                for (int b = 0; b < 4; b++) begin
                    if (fifo[fwd_idx].mask[b]) begin
                        fwd_mask[b]          = 1'b1;
                        fwd_data[b*8 +: 8]   = fifo[fwd_idx].data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Entry storage needs no reset: validity comes from count
    always_ff @(posedge clk) begin
        if (st_fire) fifo[wr_ptr] <= st_entry;
    end

    // FIFO pointers, occupancy and registered empty flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sb_empty <= 1'b1;
        end else begin
            if (st_fire) wr_ptr <= wr_ptr + PW'(1);
            if (drain)   rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nxt;
            sb_empty <= (count_nxt == '0);
        end
    end

    // Load response pipeline stage and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            r_fmask    <= 4'b0000;
            r_fdata    <= 32'h0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            err        <= 1'b0;
        end else begin
            resp_valid <= ld_fire;
            err        <= (st_valid && st_ready && st_bad) || (ld_valid && ld_bad);
            if (ld_fire) begin
                resp_tag <= ld_tag;
                r_fmask  <= fwd_mask;
                r_fdata  <= fwd_data;
                r_off    <= ld_addr[1:0];
                r_size   <= ld_size;
                r_uns    <= ld_unsigned;
            end
        end
    end

    // Merge forwarded lanes over SRAM data, align to bit 0, then extend
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = r_fmask[b] ? r_fdata[b*8 +: 8] : dout1[b*8 +: 8];
        end
        shifted = merged >> {r_off, 3'b000};
        case (r_size)
            2'b00:   resp_data = {{24{!r_uns && shifted[7]}}, shifted[7:0]};
            2'b01:   resp_data = {{16{!r_uns && shifted[15]}}, shifted[15:0]};
            default: resp_data = shifted;
        endcase
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer with a byte-level memory model and response scoreboard.
// Latency: checks load responses one cycle after issue and SRAM port drive in the issuing cycle.
// Backpressure: the model tracks store FIFO occupancy to predict st_ready.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [9:0]  st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [9:0]  ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [3:0]  ld_tag;
    logic        resp_valid;
    logic [3:0]  resp_tag;
    logic [31:0] resp_data;
    logic        err, sb_empty, csb0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0, dout1;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_tag(ld_tag),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
        .err(err), .sb_empty(sb_empty),
        .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    // SRAM macro model: registered read, byte-masked write
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (!csb1) dout1 <= sram[addr1];
        if (!csb0) begin
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) sram[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
    end

    typedef struct { logic [7:0] waddr; logic [3:0] mask; logic [31:0] data; } pend_t;
    typedef struct { logic [3:0] tag; logic [31:0] data; } resp_t;

    logic [7:0] ref_mem [1024];   // architectural memory: every accepted store applied at once
    pend_t      pq[$];            // stores accepted but not yet written to SRAM
    resp_t      sb[$];            // expected load responses
    int         vectors = 0;
    int         miscompares = 0;
    logic       err_pend = 1'b0;
    logic       ld_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit misal(input logic [9:0] a, input logic [1:0] s);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] s, input logic u);
        int n = 1 << s;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (!u && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: pop the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin : monitor
        resp_t e;
        if (!rst && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got tag %h data %h expected none", resp_tag, resp_data);
            end else begin
                e = sb.pop_front();
                check("resp_tag", {28'h0, resp_tag}, {28'h0, e.tag});
                check("resp_data", resp_data, e.data);
            end
        end
    end

    // One clock of stimulus: entered and left at posedge+1
    task automatic do_cycle(input logic sv, input logic [9:0] sa, input logic [1:0] ss, input logic [31:0] sd,
                            input logic lv, input logic [9:0] la, input logic [1:0] ls, input logic lu,
                            input logic [3:0] lt, input bit use_c, input logic [31:0] cval);
        bit st_bad, ld_bad, full, st_acc, ld_acc, drn;
        pend_t hd, ne;
        logic [31:0] bm;
        int n;
        st_valid = sv; st_addr = sa; st_size = ss; st_data = sd;
        ld_valid = lv; ld_addr = la; ld_size = ls; ld_unsigned = lu; ld_tag = lt;
        st_bad = sv && misal(sa, ss);
        ld_bad = lv && misal(la, ls);
        full   = (pq.size() >= DEPTH);
        st_acc = sv && !st_bad && !full;
        ld_acc = lv && !ld_bad;
        if (ld_acc) sb.push_back('{lt, use_c ? cval : ref_load(la, ls, lu)});
        drn = 1'b0;
        if (pq.size() > 0) begin
            hd  = pq[0];
            drn = !(ld_acc && hd.waddr == la[9:2]);
        end
        @(negedge clk);
        check("st_ready", {31'h0, st_ready}, {31'h0, !full});
        check("sb_empty", {31'h0, sb_empty}, {31'h0, pq.size() == 0});
        check("err", {31'h0, err}, {31'h0, err_pend});
        check("resp_valid", {31'h0, resp_valid}, {31'h0, ld_prev});
        check("csb0", {31'h0, csb0}, {31'h0, !drn});
        if (drn) begin
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{hd.mask[b]}};
            check("addr0", {24'h0, addr0}, {24'h0, hd.waddr});
            check("wmask0", {28'h0, wmask0}, {28'h0, hd.mask});
            check("din0", din0 & bm, hd.data & bm);
        end else begin
            check("wmask0_idle", {28'h0, wmask0}, 32'h0);
        end
        check("csb1", {31'h0, csb1}, {31'h0, !ld_acc});
        if (ld_acc) check("addr1", {24'h0, addr1}, {24'h0, la[9:2]});
        err_pend = (sv && !full && st_bad) || ld_bad;
        ld_prev  = ld_acc;
        if (drn) void'(pq.pop_front());
        if (st_acc) begin
            n = 1 << ss;
            for (int i = 0; i < n; i++) ref_mem[int'(sa) + i] = sd[8*i +: 8];
            ne.waddr = sa[9:2];
            ne.mask  = 4'(((1 << n) - 1) << sa[1:0]);
            ne.data  = sd << (8 * sa[1:0]);
            pq.push_back(ne);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_inputs();
        st_valid = 0; st_addr = 0; st_size = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; ld_size = 0; ld_unsigned = 0; ld_tag = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_st_ready", {31'h0, st_ready}, 32'h1);
        check("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_csb0", {31'h0, csb0}, 32'h1);
        check("rst_csb1", {31'h0, csb1}, 32'h1);
        check("rst_wmask0", {28'h0, wmask0}, 32'h0);
        check("rst_addr0", {24'h0, addr0}, 32'h0);
        check("rst_din0", din0, 32'h0);
    endtask

    initial begin
        logic [9:0]  ra, la;
        logic [1:0]  rs, ls;
        rst = 1'b1;
        clear_inputs();
        for (int w = 0; w < 256; w++) begin
            sram[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = sram[w][b*8 +: 8];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Word store drains next cycle, then reads back
        do_cycle(1, 10'h010, 2'b10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        do_cycle(0, 0, 0, 0, 1, 10'h010, 2'b10, 0, 4'h1, 1, 32'hDEADBEEF);
        // Byte store forwarded into a word load while the drain is held off
        do_cycle(1, 10'h013, 2'b00, 32'h000000AB, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 10'h010, 2'b10, 0, 4'h2, 1, 32'hABADBEEF);
        idle(2);

        // Fill the FIFO behind same-word loads; fifth store waits then lands last
        do_cycle(1, 10'h080, 2'b00, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 10'h080, 2'b00, 32'h22, 1, 10'h080, 2'b10, 0, 4'h3, 0, 0);
        do_cycle(1, 10'h080, 2'b00, 32'h33, 1, 10'h080, 2'b00, 1, 4'h4, 0, 0);
        do_cycle(1, 10'h080, 2'b00, 32'h44, 1, 10'h080, 2'b00, 1, 4'h5, 1, 32'h33);
        do_cycle(1, 10'h080, 2'b00, 32'h55, 1, 10'h080, 2'b00, 1, 4'h6, 1, 32'h44);
        do_cycle(1, 10'h080, 2'b00, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 10'h080, 2'b00, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        do_cycle(0, 0, 0, 0, 1, 10'h080, 2'b00, 1, 4'h7, 1, 32'h55);

        // Sign/zero extension
        do_cycle(1, 10'h010, 2'b10, 32'h80011234, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        do_cycle(0, 0, 0, 0, 1, 10'h013, 2'b00, 0, 4'h8, 1, 32'hFFFFFF80);
        do_cycle(0, 0, 0, 0, 1, 10'h013, 2'b00, 1, 4'h9, 1, 32'h00000080);
        do_cycle(0, 0, 0, 0, 1, 10'h012, 2'b01, 0, 4'hA, 1, 32'hFFFF8001);

        // Misaligned store and load together: one err pulse, nothing queued or issued
        do_cycle(1, 10'h011, 2'b01, 32'h1234, 1, 10'h012, 2'b10, 0, 4'hB, 0, 0);
        idle(2);

        // Reset with three stores pending and a load in flight
        do_cycle(1, 10'h0C0, 2'b10, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 10'h0C4, 2'b10, 32'h01020304, 1, 10'h0C0, 2'b10, 0, 4'hC, 0, 0);
        do_cycle(1, 10'h0C8, 2'b10, 32'h05060708, 1, 10'h0C0, 2'b10, 0, 4'hD, 0, 0);
        rst = 1'b1;
        clear_inputs();
        sb.delete();
        pq.delete();
        err_pend = 1'b0;
        ld_prev  = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = sram[w][b*8 +: 8];
        idle(4);

        // Random traffic over a few words to exercise forwarding and drain suppression
        for (int i = 0; i < 400; i++) begin
            rs = 2'($urandom_range(0, 2));
            ra = {5'h0, 3'($urandom_range(0, 7)), 2'b00} | 10'(($urandom_range(0, 3) << rs) & 3);
            ls = 2'($urandom_range(0, 2));
            la = {5'h0, 3'($urandom_range(0, 7)), 2'b00} | 10'(($urandom_range(0, 3) << ls) & 3);
            if ($urandom_range(0, 9) == 0) begin ra = 10'($urandom_range(0, 31)); rs = 2'($urandom_range(0, 3)); end
            if ($urandom_range(0, 9) == 0) begin la = 10'($urandom_range(0, 31)); ls = 2'($urandom_range(0, 3)); end
            do_cycle(1'($urandom_range(0, 1)), ra, rs, $urandom,
                     1'($urandom_range(0, 1)), la, ls, 1'($urandom_range(0, 1)), 4'($urandom), 0, 0);
        end
        idle(8);

        check("sb_leftover", sb.size(), 0);
        for (int w = 0; w < 256; w++)
            check("sram_final", sram[w],
                  {ref_mem[w*4 + 3], ref_mem[w*4 + 2], ref_mem[w*4 + 1], ref_mem[w*4]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
